// File: rtl/timeset_controller.sv
// timeset_controller
//   Press-and-hold sequencer for clock time-setting. Arbitrates the hour-set
//   and minute-set buttons onto one shared timeset strobe divider and emits
//   one-cycle increment pulses: one immediately on press, then slow
//   auto-repeat, then fast auto-repeat after SLOW_REPEATS slow steps.
//
//   Parameters:
//     SLOW_REPEATS  slow-rate repeat pulses before switching to fast (1..255)
//
//   Ports:
//     i_clk          system clock
//     i_reset_n      synchronous reset, active-low
//     i_en           set-mode enable; low forces IDLE
//     i_set_hr       hour-set button, debounced level, 1=pressed
//     i_set_min      minute-set button, debounced level, 1=pressed
//     i_timeset_stb  one-cycle strobe from the timeset divider
//     o_div_en       divider enable
//     o_div_fast     divider speed select (1 fast, 0 slow)
//     o_div_reset_n  divider sync reset, active-low
//     o_hr_inc       one-cycle hour increment pulse
//     o_min_inc      one-cycle minute increment pulse
//     o_busy         high whenever not IDLE
module timeset_controller #(
    parameter int unsigned SLOW_REPEATS = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_set_hr,
    input  logic i_set_min,
    input  logic i_timeset_stb,
    output logic o_div_en,
    output logic o_div_fast,
    output logic o_div_reset_n,
    output logic o_hr_inc,
    output logic o_min_inc,
    output logic o_busy
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SLOW = 2'd1,
        S_FAST = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HR   = 2'd1,
        OWN_MIN  = 2'd2
    } owner_t;

    state_t             r_state;
    owner_t             r_owner;
    logic [CNT_W-1:0]   r_count;
    logic               r_div_en;
    logic               r_div_fast;
    logic               r_div_reset_n;
    logic               r_hr_inc;
    logic               r_min_inc;
    logic               r_busy;

    state_t             w_state;
    owner_t             w_owner;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_pulse;
    logic               w_owner_btn;
    logic               w_stb;

    // Level of the button currently owning the hold
    always_comb begin
        w_owner_btn = 1'b0;
        case (r_owner)
            OWN_HR:  w_owner_btn = i_set_hr;
            OWN_MIN: w_owner_btn = i_set_min;
            default: w_owner_btn = 1'b0;
        endcase
    end

    // A strobe landing right after a pulse is dropped so increments never
    // run back-to-back (only possible right after the immediate press pulse).
    assign w_stb       = i_timeset_stb && !(r_hr_inc || r_min_inc);
    assign w_count_inc = r_count + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        w_state = r_state;
        w_owner = r_owner;
        w_count = r_count;
        w_pulse = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_owner = OWN_NONE;
                w_count = '0;
                if (i_en && i_set_hr) begin
                    w_state = S_SLOW;
                    w_owner = OWN_HR;
                    w_pulse = 1'b1;
                end else if (i_en && i_set_min) begin
                    w_state = S_SLOW;
                    w_owner = OWN_MIN;
                    w_pulse = 1'b1;
                end
            end
            S_SLOW: begin
                if (!i_en || !w_owner_btn) begin
                    w_state = S_IDLE;
                    w_owner = OWN_NONE;
                    w_count = '0;
                end else if (w_stb) begin
                    w_pulse = 1'b1;
                    w_count = w_count_inc;
                    if (w_count_inc == CNT_W'(SLOW_REPEATS)) begin
                        w_state = S_FAST;
                    end
                end
            end
            S_FAST: begin
                if (!i_en || !w_owner_btn) begin
                    w_state = S_IDLE;
                    w_owner = OWN_NONE;
                    w_count = '0;
                end else if (w_stb) begin
                    w_pulse = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_owner = OWN_NONE;
                w_count = '0;
            end
        endcase
    end

    // State and registered outputs; outputs reflect the state being entered
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_owner       <= OWN_NONE;
            r_count       <= '0;
            r_div_en      <= 1'b0;
            r_div_fast    <= 1'b0;
            r_div_reset_n <= 1'b0;
            r_hr_inc      <= 1'b0;
            r_min_inc     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_owner       <= w_owner;
            r_count       <= w_count;
            r_div_en      <= (w_state != S_IDLE);
            r_div_fast    <= (w_state == S_FAST);
            r_div_reset_n <= (w_state != S_IDLE);
            r_hr_inc      <= w_pulse && (w_owner == OWN_HR);
            r_min_inc     <= w_pulse && (w_owner == OWN_MIN);
            r_busy        <= (w_state != S_IDLE);
        end
    end

    assign o_div_en      = r_div_en;
    assign o_div_fast    = r_div_fast;
    assign o_div_reset_n = r_div_reset_n;
    assign o_hr_inc      = r_hr_inc;
    assign o_min_inc     = r_min_inc;
    assign o_busy        = r_busy;

endmodule
